multi_cycle_control: RTL and testbench
======================================

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, maximum wait cycles for mem_ready_i per memory access before trapping (1..255).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: opcode_i  input  7  instruction[6:0] from the instruction register.
REQ-005 Port: branch_taken_i  input  1  branch condition, computed externally from the ALU flags.
REQ-006 Port: mem_ready_i  input  1  unified memory completes the current request this cycle.
REQ-007 Port: mem_req_o  output  1  memory request; held high until mem_ready_i.
REQ-008 Port: mem_write_o / i_or_d_o  output  1 each  store strobe; address select (0 = PC, 1 = ALU result).
REQ-009 Port: ir_write_o / pc_write_o / reg_write_o  output  1 each  IR, PC and register-file write enables.
REQ-010 Port: pc_src_o  output  2  next-PC select (00 = PC+4, 01 = PC+imm, 10 = ALU result).
REQ-011 Port: alu_src_b_o  output  1  ALU B select (0 = rs2, 1 = immediate).
REQ-012 Port: alu_op_o  output  3  class code for ALU_Control (000 = add, 001 = branch compare, 010 = R-type, 011 = I-type, 100 = LUI pass).
REQ-013 Port: result_src_o  output  2  write-back select (00 = ALU, 01 = memory, 10 = PC+4).
REQ-014 Port: state_o  output  3  current state; trap_o  output  1; instr_done_o  output  1  one-cycle retire pulse.

Function
REQ-015 States and state_o encodings SHALL be: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, TRAP=7; state 6 is unreachable and SHALL decode to TRAP.
REQ-016 Outputs SHALL be decoded from the state register and opcode_i only (Moore, plus opcode qualification); every enable SHALL be 0 in any state not listed below.
REQ-017 IDLE: all outputs 0; next state FETCH unconditionally.
REQ-018 FETCH: mem_req_o=1, i_or_d_o=0; on mem_ready_i: ir_write_o=1, pc_write_o=1, pc_src_o=00, next DECODE; otherwise remain in FETCH.
REQ-019 DECODE: legal opcodes are 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111 -> EXECUTE; any other opcode -> TRAP; no enables asserted.
REQ-020 EXECUTE branch: alu_op_o=001; pc_write_o=branch_taken_i, pc_src_o=01; instr_done_o=1; next FETCH.
REQ-021 EXECUTE JAL: pc_write_o=1, pc_src_o=01; next WB. EXECUTE JALR: alu_src_b_o=1, alu_op_o=000, pc_write_o=1, pc_src_o=10; next WB.
REQ-022 EXECUTE load/store: alu_src_b_o=1, alu_op_o=000; next MEM. R-type: alu_op_o=010. I-type: alu_src_b_o=1, alu_op_o=011. LUI: alu_src_b_o=1, alu_op_o=100. For R-type, I-type and LUI, next state is WB.
REQ-023 MEM: mem_req_o=1, i_or_d_o=1, alu_src_b_o=1, mem_write_o=1 for store only; on mem_ready_i: store -> instr_done_o=1 and next FETCH; load -> next WB.
REQ-024 WB: reg_write_o=1; result_src_o=01 for load, 10 for JAL/JALR, 00 otherwise; instr_done_o=1; next FETCH.
REQ-025 Wait counter: 8 bits; cleared on entry to FETCH or MEM; increments each cycle that mem_req_o=1 and mem_ready_i=0; when the count reaches TIMEOUT_CYCLES with mem_ready_i still 0, next state SHALL be TRAP.
REQ-026 mem_ready_i arriving on the same cycle the count reaches TIMEOUT_CYCLES SHALL win: the access completes normally with no trap.
REQ-027 mem_ready_i SHALL be ignored in every state except FETCH and MEM.
REQ-028 TRAP: trap_o=1, all enables 0; sticky until reset.
REQ-029 opcode_i SHALL be sampled only from IR contents, so it is stable from DECODE through WB.

Reset
REQ-030 Asserting reset (low) SHALL immediately, without a clock edge, force state IDLE, clear the wait counter, and drive all outputs to 0, including during a pending memory access.
REQ-031 After reset deasserts, the first rising edge SHALL move IDLE to FETCH; mem_req_o first rises one cycle after reset release.

Verification
REQ-032 addi with mem_ready_i=1 whenever requested -> states 1,2,3,5,1; instr_done_o pulses in WB; alu_op_o=011 in EXECUTE; result_src_o=00.
REQ-033 lw with mem_ready_i delayed 3 cycles in MEM -> MEM held 4 cycles with mem_req_o=1, i_or_d_o=1, mem_write_o=0; then WB with result_src_o=01.
REQ-034 beq with branch_taken_i=1, then with branch_taken_i=0 -> pc_write_o=1/pc_src_o=01 in EXECUTE for the first; pc_write_o=0 for the second; each retires in 3 states.
REQ-035 TIMEOUT_CYCLES=4, mem_ready_i held 0 in FETCH -> TRAP entered after 4 wait cycles; trap_o=1 held; ready arriving on the 4th wait cycle instead -> no trap.
REQ-036 Opcode 0000000 -> TRAP from DECODE; reset pulsed low mid-MEM -> outputs 0 asynchronously, then IDLE -> FETCH.

Source files
------------

// File: rtl/multi_cycle_control.sv
// Main control FSM for a multi-cycle RV32I core with a unified memory port.
// Drives the datapath enables per state, bounds every memory access with a
// wait counter and traps on illegal opcodes or memory timeouts.
module multi_cycle_control #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode_i,
  input  logic       branch_taken_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic       i_or_d_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic [1:0] pc_src_o,
  output logic       alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic [1:0] result_src_o,
  output logic [2:0] state_o,
  output logic       trap_o,
  output logic       instr_done_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  // The access traps when this wait would be the TIMEOUT_CYCLES-th one.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout;

  assign timeout = !mem_ready_i && (wait_cnt_q == LAST_WAIT);
  assign state_o = state_q;

  // NOTE: every output and next-state signal gets a default before the case
  // so no path through the block leaves a value unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = 8'd0;
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    i_or_d_o     = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    pc_src_o     = 2'b00;
    alu_src_b_o  = 1'b0;
    alu_op_o     = 3'b000;
    result_src_o = 2'b00;
    trap_o       = 1'b0;
    instr_done_o = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      S_DECODE: begin
        case (opcode_i)
          OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI:
            state_d = S_EXEC;
          default: state_d = S_TRAP;
        endcase
      end

      S_EXEC: begin
        case (opcode_i)
          OP_BR: begin
            alu_op_o     = 3'b001;
            pc_write_o   = branch_taken_i;
            pc_src_o     = 2'b01;
            instr_done_o = 1'b1;
            state_d      = S_FETCH;
          end
          OP_JAL: begin
            pc_write_o = 1'b1;
            pc_src_o   = 2'b01;
            state_d    = S_WB;
          end
          OP_JALR: begin
            alu_src_b_o = 1'b1;
            pc_write_o  = 1'b1;
            pc_src_o    = 2'b10;
            state_d     = S_WB;
          end
          OP_LD, OP_ST: begin
            alu_src_b_o = 1'b1;
            state_d     = S_MEM;
          end
          OP_R: begin
            alu_op_o = 3'b010;
            state_d  = S_WB;
          end
          OP_I: begin
            alu_src_b_o = 1'b1;
            alu_op_o    = 3'b011;
            state_d     = S_WB;
          end
          OP_LUI: begin
            alu_src_b_o = 1'b1;
            alu_op_o    = 3'b100;
            state_d     = S_WB;
          end
          default: state_d = S_TRAP;
        endcase
      end

      S_MEM: begin
        mem_req_o   = 1'b1;
        i_or_d_o    = 1'b1;
        alu_src_b_o = 1'b1;
        mem_write_o = (opcode_i == OP_ST);
        if (mem_ready_i) begin
          if (opcode_i == OP_ST) begin
            instr_done_o = 1'b1;
            state_d      = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d = S_TRAP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      S_WB: begin
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
        if (opcode_i == OP_LD) begin
          result_src_o = 2'b01;
        end else if (opcode_i == OP_JAL || opcode_i == OP_JALR) begin
          result_src_o = 2'b10;
        end
        state_d = S_FETCH;
      end

      // TRAP and the unused encoding 6 both hold here until reset.
      default: begin
        trap_o  = 1'b1;
        state_d = S_TRAP;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control: each instruction is expanded
// into its expected per-cycle output trace, then replayed against the DUT.
module tb_multi_cycle_control;

  localparam int TO = 4;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef struct packed {
    logic [2:0] st;
    logic       trap;
    logic       done;
    logic       req;
    logic       wr;
    logic       iod;
    logic       irw;
    logic       pcw;
    logic       rw;
    logic [1:0] pcs;
    logic       asb;
    logic [2:0] aop;
    logic [1:0] rs;
  } out_t;

  typedef struct {
    logic [6:0] op;
    logic       bt;
    logic       rdy;
    out_t       exp;
  } step_t;

  logic       clk;
  logic       reset;
  logic [6:0] opcode_i;
  logic       branch_taken_i;
  logic       mem_ready_i;
  logic       mem_req_o, mem_write_o, i_or_d_o, ir_write_o, pc_write_o, reg_write_o;
  logic [1:0] pc_src_o;
  logic       alu_src_b_o;
  logic [2:0] alu_op_o;
  logic [1:0] result_src_o;
  logic [2:0] state_o;
  logic       trap_o, instr_done_o;

  step_t      q[$];
  logic [6:0] prev_op;
  int         vectors;
  int         miscompares;
  string      tag;

  multi_cycle_control #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .opcode_i       (opcode_i),
    .branch_taken_i (branch_taken_i),
    .mem_ready_i    (mem_ready_i),
    .mem_req_o      (mem_req_o),
    .mem_write_o    (mem_write_o),
    .i_or_d_o       (i_or_d_o),
    .ir_write_o     (ir_write_o),
    .pc_write_o     (pc_write_o),
    .reg_write_o    (reg_write_o),
    .pc_src_o       (pc_src_o),
    .alu_src_b_o    (alu_src_b_o),
    .alu_op_o       (alu_op_o),
    .result_src_o   (result_src_o),
    .state_o        (state_o),
    .trap_o         (trap_o),
    .instr_done_o   (instr_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t blank(input logic [2:0] st);
    out_t o;
    o    = '0;
    o.st = st;
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [6:0] op, input logic bt, input logic rdy, input out_t e);
    step_t s;
    s.op  = op;
    s.bt  = bt;
    s.rdy = rdy;
    s.exp = e;
    q.push_back(s);
  endtask

  task automatic push_trap();
    out_t t;
    t      = blank(3'd7);
    t.trap = 1'b1;
    for (int i = 0; i < 3; i++) push(7'($urandom), rb(), rb(), t);
  endtask

  // One memory access: 'waits' not-ready cycles, then a ready cycle, unless
  // the wait budget runs out first.
  task automatic mem_phase(input logic iside, input int waits, input logic [6:0] op,
                           input logic is_store, output logic ok);
    out_t e;
    e     = blank(iside ? 3'd1 : 3'd4);
    e.req = 1'b1;
    if (!iside) begin
      e.iod = 1'b1;
      e.asb = 1'b1;
      e.wr  = is_store;
    end
    for (int i = 0; i < waits && i < TO; i++) push(op, rb(), 1'b0, e);
    if (waits >= TO) begin
      push_trap();
      ok = 1'b0;
      return;
    end
    if (iside) begin
      e.irw = 1'b1;
      e.pcw = 1'b1;
    end else if (is_store) begin
      e.done = 1'b1;
    end
    push(op, rb(), 1'b1, e);
    ok = 1'b1;
  endtask

  task automatic add_instr(input logic [6:0] op, input int fw, input int mw,
                           input logic bt, output logic trapped);
    out_t e;
    logic ok;
    trapped = 1'b1;
    mem_phase(1'b1, fw, prev_op, 1'b0, ok);
    if (!ok) return;
    prev_op = op;
    push(op, rb(), rb(), blank(3'd2));
    if (!(op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI})) begin
      push_trap();
      return;
    end
    e = blank(3'd3);
    case (op)
      OP_BR: begin
        e.aop  = 3'd1;
        e.pcw  = bt;
        e.pcs  = 2'd1;
        e.done = 1'b1;
        push(op, bt, rb(), e);
        trapped = 1'b0;
        return;
      end
      OP_JAL:       begin e.pcw = 1'b1; e.pcs = 2'd1; end
      OP_JALR:      begin e.asb = 1'b1; e.pcw = 1'b1; e.pcs = 2'd2; end
      OP_LD, OP_ST: e.asb = 1'b1;
      OP_R:         e.aop = 3'd2;
      OP_I:         begin e.asb = 1'b1; e.aop = 3'd3; end
      default:      begin e.asb = 1'b1; e.aop = 3'd4; end
    endcase
    push(op, rb(), rb(), e);
    if (op == OP_LD || op == OP_ST) begin
      mem_phase(1'b0, mw, op, op == OP_ST, ok);
      if (!ok) return;
      if (op == OP_ST) begin
        trapped = 1'b0;
        return;
      end
    end
    e      = blank(3'd5);
    e.rw   = 1'b1;
    e.done = 1'b1;
    e.rs   = (op == OP_LD) ? 2'd1 : (op == OP_JAL || op == OP_JALR) ? 2'd2 : 2'd0;
    push(op, rb(), rb(), e);
    trapped = 1'b0;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t obs;
    obs = {state_o, trap_o, instr_done_o, mem_req_o, mem_write_o, i_or_d_o, ir_write_o,
           pc_write_o, reg_write_o, pc_src_o, alu_src_b_o, alu_op_o, result_src_o};
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Entered and left just after a rising edge; outputs checked on the falling edge.
  task automatic run_q();
    step_t s;
    int    n;
    n = 0;
    while (q.size() > 0) begin
      s              = q.pop_front();
      opcode_i       = s.op;
      branch_taken_i = s.bt;
      mem_ready_i    = s.rdy;
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, n), s.exp);
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string name);
    #2 reset = 1'b0;
    #1 check(name, blank(3'd0));
    @(posedge clk);
    #1 reset = 1'b1;
    push(prev_op, rb(), rb(), blank(3'd0));
  endtask

  initial begin
    logic       tr;
    logic [6:0] legal[8];
    logic [6:0] op;
    int         fw, mw;

    legal          = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI};
    vectors        = 0;
    miscompares    = 0;
    prev_op        = 7'd0;
    reset          = 1'b0;
    opcode_i       = 7'd0;
    branch_taken_i = 1'b0;
    mem_ready_i    = 1'b1;

    #2 check("reset", blank(3'd0));
    @(posedge clk);
    #1 reset = 1'b1;
    push(prev_op, rb(), rb(), blank(3'd0));

    tag = "addi";        add_instr(OP_I, 0, 0, 1'b0, tr);    run_q();
    tag = "lw_mem3";     add_instr(OP_LD, 0, 3, 1'b0, tr);   run_q();
    tag = "beq_taken";   add_instr(OP_BR, 0, 0, 1'b1, tr);   run_q();
    tag = "beq_nottkn";  add_instr(OP_BR, 0, 0, 1'b0, tr);   run_q();
    tag = "sw";          add_instr(OP_ST, 1, 2, 1'b0, tr);   run_q();
    tag = "jal";         add_instr(OP_JAL, 2, 0, 1'b0, tr);  run_q();
    tag = "jalr";        add_instr(OP_JALR, 0, 0, 1'b1, tr); run_q();
    tag = "lui";         add_instr(OP_LUI, 1, 0, 1'b0, tr);  run_q();
    tag = "rtype";       add_instr(OP_R, 0, 0, 1'b1, tr);    run_q();
    tag = "fetch_rdy4";  add_instr(OP_R, TO - 1, 0, 1'b0, tr); run_q();

    tag = "fetch_tmo";   add_instr(OP_I, TO, 0, 1'b0, tr);   run_q();
    do_reset("fetch_tmo_rst");
    tag = "mem_tmo";     add_instr(OP_ST, 0, TO + 2, 1'b0, tr); run_q();
    do_reset("mem_tmo_rst");
    tag = "illegal";     add_instr(7'b0000000, 0, 0, 1'b0, tr); run_q();
    do_reset("illegal_rst");

    // Stop two cycles short of the load completing, then reset mid-access.
    tag = "rst_mid_mem"; add_instr(OP_LD, 0, 3, 1'b0, tr);
    void'(q.pop_back());
    void'(q.pop_back());
    run_q();
    do_reset("rst_mid_mem_rst");

    tag = "rand";
    for (int i = 0; i < 60; i++) begin
      op = legal[$urandom_range(0, 7)];
      if ($urandom_range(0, 11) == 0) op = 7'($urandom);
      fw = ($urandom_range(0, 9) == 0) ? $urandom_range(TO, TO + 1) : $urandom_range(0, TO - 1);
      mw = ($urandom_range(0, 9) == 0) ? $urandom_range(TO, TO + 1) : $urandom_range(0, TO - 1);
      add_instr(op, fw, mw, rb(), tr);
      run_q();
      if (tr) do_reset("rand_rst");
    end
    run_q();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
